hw9_sdivdp: RTL and testbench

HW9_SDIVDP -- requirements
Module: hw9_sdivdp

---
 rtl/hw9_sdivdp_pkg.sv | 23 ++
 rtl/hw9_addsub.sv | 27 ++
 rtl/hw9_sdivdp.sv | 130 +++++++++++++
 tb/tb_hw9_sdivdp.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/hw9_sdivdp_pkg.sv
// hw9_sdivdp_pkg -- shared definitions for the restoring-division datapath.
//   WIDTH_DEF    : default operand width
//   cnt_width()  : width of the iteration counter for a given operand width
//   CNT_W_DEF    : counter width for the default operand width
//   CNT_IDLE_DEF : counter value that means idle/done (equals the operand width)
//   as_mode_e    : adder/subtractor mode select
package hw9_sdivdp_pkg;

    localparam int unsigned WIDTH_DEF = 8;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

    localparam int unsigned CNT_W_DEF    = cnt_width(WIDTH_DEF);
    localparam int unsigned CNT_IDLE_DEF = WIDTH_DEF;

    typedef enum logic {
        AS_ADD = 1'b0,
        AS_SUB = 1'b1
    } as_mode_e;

endpackage

// File: rtl/hw9_addsub.sv
// hw9_addsub -- W-bit adder/subtractor, result modulo 2^W.
//   a_i    : first operand
//   b_i    : second operand
//   mode_i : AS_ADD -> a+b, AS_SUB -> a-b
//   y_o    : result
module hw9_addsub
    import hw9_sdivdp_pkg::*;
#(
    parameter int unsigned W = WIDTH_DEF + 1
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  as_mode_e     mode_i,
    output logic [W-1:0] y_o
);

    logic         sub;
    logic [W-1:0] b_eff;

    // Two's-complement subtract: invert b and inject a carry of 1.
    always_comb begin
        sub   = (mode_i == AS_SUB);
        b_eff = sub ? ~b_i : b_i;
        y_o   = a_i + b_eff + {{(W-1){1'b0}}, sub};
    end

endmodule

// File: rtl/hw9_sdivdp.sv
// hw9_sdivdp -- restoring sequential-divider datapath driven by an external
// controller via single-cycle strobes.
//   clk, reset_n        : clock, asynchronous active-low reset
//   Load                : capture Dividend/Divisor and start a new division
//   Shift/Sub/Compare   : per-iteration steps (priority Load>Shift>Sub>Compare)
//   Enable              : qualifies Compare
//   Dividend, Divisor   : unsigned operands, sampled on Load
//   End                 : one-cycle completion pulse
//   Quotient, Remainder : result registers (meaningful while Valid)
//   Valid               : result ready, held until next Load
//   DivZero             : divisor was zero at Load
//   Count               : completed iterations; WIDTH means idle/done
module hw9_sdivdp
    import hw9_sdivdp_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   Load,
    input  logic                   Shift,
    input  logic                   Sub,
    input  logic                   Compare,
    input  logic                   Enable,
    input  logic [WIDTH-1:0]       Dividend,
    input  logic [WIDTH-1:0]       Divisor,
    output logic                   End,
    output logic [WIDTH-1:0]       Quotient,
    output logic [WIDTH-1:0]       Remainder,
    output logic                   Valid,
    output logic                   DivZero,
    output logic [$clog2(WIDTH):0] Count
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_IDLE = CW'(WIDTH);

    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]    count_q, count_d;
    logic             end_q, end_d;
    logic             valid_q, valid_d;
    logic             dz_q, dz_d;

    logic             busy;
    logic [CW-1:0]    cnt_inc;
    as_mode_e         as_mode;
    logic [WIDTH:0]   as_y;

    // One adder serves both the Sub step (subtract) and the restore (add).
    hw9_addsub #(.W(WIDTH + 1)) u_addsub (
        .a_i    (a_q),
        .b_i    ({1'b0, m_q}),
        .mode_i (as_mode),
        .y_o    (as_y)
    );

    always_comb begin
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        count_d = count_q;
        end_d   = 1'b0;
        valid_d = valid_q;
        dz_d    = dz_q;
        busy    = (count_q < CNT_IDLE);
        cnt_inc = count_q + 1'b1;
        as_mode = (!Load && !Shift && Sub) ? AS_SUB : AS_ADD;

        if (Load) begin
            a_d     = '0;
            q_d     = Dividend;
            m_d     = Divisor;
            count_d = '0;
            valid_d = 1'b0;
            dz_d    = (Divisor == '0);
        end else if (Shift) begin
            if (busy) begin
                {a_d, q_d} = {a_q[WIDTH-1:0], q_q, 1'b0};
            end
        end else if (Sub) begin
            if (busy) begin
                a_d = as_y;
            end
        end else if (Compare) begin
            if (Enable && busy) begin
                if (a_q[WIDTH]) begin
                    a_d    = as_y;
                    q_d[0] = 1'b0;
                end else begin
                    q_d[0] = 1'b1;
                end
                count_d = cnt_inc;
                if (cnt_inc == CNT_IDLE) begin
                    end_d   = 1'b1;
                    valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            count_q <= CNT_IDLE;
            end_q   <= 1'b0;
            valid_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            count_q <= count_d;
            end_q   <= end_d;
            valid_q <= valid_d;
            dz_q    <= dz_d;
        end
    end

    assign End       = end_q;
    assign Quotient  = q_q;
    assign Remainder = a_q[WIDTH-1:0];
    assign Valid     = valid_q;
    assign DivZero   = dz_q;
    assign Count     = count_q;

endmodule

// File: tb/tb_hw9_sdivdp.sv
module tb_hw9_sdivdp;

    localparam int unsigned W = 8;

    logic                 clk;
    logic                 reset_n;
    logic                 Load, Shift, Sub, Compare, Enable;
    logic [W-1:0]         Dividend, Divisor;
    logic                 End;
    logic [W-1:0]         Quotient, Remainder;
    logic                 Valid, DivZero;
    logic [$clog2(W):0]   Count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc_idx = 0;
    int end_cnt = 0;
    int end_at  = 0;

    hw9_sdivdp #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .Load      (Load),
        .Shift     (Shift),
        .Sub       (Sub),
        .Compare   (Compare),
        .Enable    (Enable),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .End       (End),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Valid     (Valid),
        .DivZero   (DivZero),
        .Count     (Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer division, divide-by-zero gives all-ones/dividend.
    function automatic logic [W-1:0] ref_q(input int dvd, input int dvs);
        if (dvs == 0) return '1;
        return W'(dvd / dvs);
    endfunction

    function automatic logic [W-1:0] ref_r(input int dvd, input int dvs);
        if (dvs == 0) return W'(dvd);
        return W'(dvd % dvs);
    endfunction

    // One clock with the given strobes; observe End afterwards.
    task automatic cyc(input logic ld, input logic sh, input logic sb,
                       input logic cp, input logic en);
        Load = ld; Shift = sh; Sub = sb; Compare = cp; Enable = en;
        @(posedge clk);
        #1;
        cyc_idx++;
        if (End === 1'b1) begin
            end_cnt++;
            end_at = cyc_idx;
        end
        Load = 1'b0; Shift = 1'b0; Sub = 1'b0; Compare = 1'b0; Enable = 1'b0;
    endtask

    task automatic iterate(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 1, 0, 0, 0);
            cyc(0, 0, 1, 0, 0);
            cyc(0, 0, 0, 1, 1);
        end
    endtask

    task automatic test_reset;
        n_cmp++; if (Quotient !== '0) begin n_err++; $display("FAIL rst_q got %0d want 0", Quotient); end
        n_cmp++; if (Remainder !== '0) begin n_err++; $display("FAIL rst_r got %0d want 0", Remainder); end
        n_cmp++; if (Count !== 4'(W)) begin n_err++; $display("FAIL rst_count got %0d want %0d", Count, W); end
        n_cmp++; if ({End, Valid, DivZero} !== 3'b000) begin n_err++; $display("FAIL rst_flags got %b want 000", {End, Valid, DivZero}); end
    endtask

    task automatic test_division(input int dvd, input int dvs);
        Dividend = W'(dvd); Divisor = W'(dvs);
        cyc_idx = 0; end_cnt = 0; end_at = 0;
        cyc(1, 0, 0, 0, 0);
        // Operands must have been captured at Load only.
        Dividend = ~W'(dvd); Divisor = W'($urandom);
        n_cmp++; if (Count !== '0 || Valid !== 1'b0 || End !== 1'b0) begin
            n_err++; $display("FAIL load_state %0d/%0d count=%0d valid=%b end=%b want 0/0/0", dvd, dvs, Count, Valid, End); end
        n_cmp++; if (Quotient !== W'(dvd) || Remainder !== '0) begin
            n_err++; $display("FAIL load_regs %0d/%0d q=%0d r=%0d want %0d/0", dvd, dvs, Quotient, Remainder, dvd); end
        n_cmp++; if (DivZero !== (dvs == 0)) begin
            n_err++; $display("FAIL divzero %0d/%0d got %b want %b", dvd, dvs, DivZero, dvs == 0); end
        iterate(W);
        n_cmp++; if (End !== 1'b1 || end_at != 3 * W + 1) begin
            n_err++; $display("FAIL end_timing %0d/%0d end=%b at=%0d want 1 at %0d", dvd, dvs, End, end_at, 3 * W + 1); end
        n_cmp++; if (Quotient !== ref_q(dvd, dvs)) begin
            n_err++; $display("FAIL quotient %0d/%0d got %0d want %0d", dvd, dvs, Quotient, ref_q(dvd, dvs)); end
        n_cmp++; if (Remainder !== ref_r(dvd, dvs)) begin
            n_err++; $display("FAIL remainder %0d/%0d got %0d want %0d", dvd, dvs, Remainder, ref_r(dvd, dvs)); end
        n_cmp++; if (Valid !== 1'b1 || Count !== 4'(W) || DivZero !== (dvs == 0)) begin
            n_err++; $display("FAIL done_flags %0d/%0d valid=%b count=%0d dz=%b", dvd, dvs, Valid, Count, DivZero); end
        cyc(0, 0, 0, 0, 0);
        n_cmp++; if (End !== 1'b0 || end_cnt != 1 || Valid !== 1'b1) begin
            n_err++; $display("FAIL end_pulse %0d/%0d end=%b pulses=%0d valid=%b want 0/1/1", dvd, dvs, End, end_cnt, Valid); end
    endtask

    task automatic test_directed;
        test_division(100, 7);
        test_division(255, 16);
        test_division(0, 5);
        test_division(13, 0);
        test_division(255, 1);
        test_division(5, 255);
    endtask

    task automatic test_reset_mid;
        Dividend = 8'd100; Divisor = 8'd7;
        cyc(1, 0, 0, 0, 0);
        iterate(3);
        cyc(0, 1, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (Quotient !== '0 || Remainder !== '0 || Count !== 4'(W)) begin
            n_err++; $display("FAIL midrst_regs q=%0d r=%0d count=%0d want 0/0/%0d", Quotient, Remainder, Count, W); end
        n_cmp++; if ({End, Valid, DivZero} !== 3'b000) begin
            n_err++; $display("FAIL midrst_flags got %b want 000", {End, Valid, DivZero}); end
        @(posedge clk); #2 reset_n = 1'b1;
        end_cnt = 0;
        iterate(W);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);
        n_cmp++; if (end_cnt != 0 || Count !== 4'(W) || Quotient !== '0 || Valid !== 1'b0) begin
            n_err++; $display("FAIL midrst_noend pulses=%0d count=%0d q=%0d valid=%b want 0/%0d/0/0", end_cnt, Count, Quotient, Valid, W); end
        test_division(100, 7);
    endtask

    task automatic test_ignore;
        int r1;
        test_division(200, 9);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 1);
        n_cmp++; if (Quotient !== ref_q(200, 9) || Remainder !== ref_r(200, 9) || Count !== 4'(W) || Valid !== 1'b1) begin
            n_err++; $display("FAIL after_done q=%0d r=%0d count=%0d valid=%b want %0d/%0d/%0d/1",
                              Quotient, Remainder, Count, Valid, ref_q(200, 9), ref_r(200, 9), W); end
        // Compare without Enable in the middle of the first iteration.
        Dividend = 8'd100; Divisor = 8'd7;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        r1 = ((100 >> (W - 1)) - 7) & ((1 << W) - 1);
        n_cmp++; if (Count !== '0 || Remainder !== W'(r1)) begin
            n_err++; $display("FAIL cmp_noen count=%0d r=%0d want 0/%0d", Count, Remainder, r1); end
        cyc(0, 0, 0, 1, 1);
        n_cmp++; if (Count !== 4'd1) begin n_err++; $display("FAIL cmp_en count=%0d want 1", Count); end
        iterate(W - 1);
        n_cmp++; if (Quotient !== 8'd14 || Remainder !== 8'd2 || Valid !== 1'b1) begin
            n_err++; $display("FAIL cmp_noen_result q=%0d r=%0d valid=%b want 14/2/1", Quotient, Remainder, Valid); end
        // Load together with Shift: the load takes effect, the shift does not.
        Dividend = 8'd77; Divisor = 8'd5;
        cyc(1, 1, 0, 0, 0);
        n_cmp++; if (Quotient !== 8'd77 || Remainder !== '0 || Count !== '0 || Valid !== 1'b0) begin
            n_err++; $display("FAIL load_shift q=%0d r=%0d count=%0d valid=%b want 77/0/0/0", Quotient, Remainder, Count, Valid); end
        iterate(W);
        n_cmp++; if (Quotient !== ref_q(77, 5) || Remainder !== ref_r(77, 5)) begin
            n_err++; $display("FAIL load_shift_result q=%0d r=%0d want %0d/%0d", Quotient, Remainder, ref_q(77, 5), ref_r(77, 5)); end
    endtask

    task automatic test_restart;
        Dividend = 8'd50; Divisor = 8'd3;
        cyc(1, 0, 0, 0, 0);
        iterate(4);
        cyc(0, 1, 0, 0, 0);
        test_division(123, 11);
    endtask

    // Controller-style loop: Start -> Load, step strobes until End, then
    // start the next division in the very next cycle.
    task automatic test_back_to_back;
        int dvd, dvs, steps;
        bit got;
        for (int k = 0; k < 3; k++) begin
            dvd = $urandom_range(0, 255);
            dvs = $urandom_range(1, 255);
            Dividend = W'(dvd); Divisor = W'(dvs);
            cyc(1, 0, 0, 0, 0);
            n_cmp++; if (End !== 1'b0 || Count !== '0) begin
                n_err++; $display("FAIL b2b_start%0d end=%b count=%0d want 0/0", k, End, Count); end
            steps = 0; got = 0;
            while (!got && steps < 40) begin
                case (steps % 3)
                    0: cyc(0, 1, 0, 0, 0);
                    1: cyc(0, 0, 1, 0, 0);
                    default: cyc(0, 0, 0, 1, 1);
                endcase
                steps++;
                if (End === 1'b1) got = 1;
            end
            n_cmp++; if (!got || steps != 3 * W) begin
                n_err++; $display("FAIL b2b_end%0d seen=%0d steps=%0d want 1/%0d", k, got, steps, 3 * W); end
            n_cmp++; if (Quotient !== ref_q(dvd, dvs) || Remainder !== ref_r(dvd, dvs)) begin
                n_err++; $display("FAIL b2b_result%0d %0d/%0d q=%0d r=%0d want %0d/%0d", k, dvd, dvs,
                                  Quotient, Remainder, ref_q(dvd, dvs), ref_r(dvd, dvs)); end
        end
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic test_random;
        int dvd, dvs;
        for (int i = 0; i < 16; i++) begin
            dvd = $urandom_range(0, 255);
            dvs = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
            test_division(dvd, dvs);
        end
    endtask

    initial begin
        Load = 0; Shift = 0; Sub = 0; Compare = 0; Enable = 0;
        Dividend = '0; Divisor = '0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1 test_reset();
        @(posedge clk); @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_reset_mid();
        test_ignore();
        test_restart();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
